// File: rtl/regfile_seq.sv
// Command sequencer driving a 16x32 register file: reads the sources, computes
// an ALU result, writes it back and returns result plus flags on a handshake.
module regfile_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_src2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic              rf_en,
  output logic              rf_rd,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_sel_i1,
  output logic [ADDR_W-1:0] rf_sel_o1,
  output logic [ADDR_W-1:0] rf_sel_o2,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_op1,
  input  logic [DATA_W-1:0] rf_op2
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPT, S_WRITE, S_RESP} state_e;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                         OP_XOR = 3'd4, OP_MOV = 3'd5, OP_LDI = 3'd6, OP_CMP = 3'd7;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   dst_q, dst_d, src1_q, src1_d, src2_q, src2_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d, carry_q, carry_d;
  logic                rdy_q, rdy_d;

  logic [DATA_W:0]     sum, diff;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;

  always_comb begin
    sum     = {1'b0, rf_op1} + {1'b0, rf_op2};
    diff    = {1'b0, rf_op1} - {1'b0, rf_op2};
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD:         begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];  end
      OP_SUB, OP_CMP: begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; end
      OP_AND:         alu_res = rf_op1 & rf_op2;
      OP_OR:          alu_res = rf_op1 | rf_op2;
      OP_XOR:         alu_res = rf_op1 ^ rf_op2;
      OP_MOV:         alu_res = rf_op1;
      default:        alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    case (state_q)
      S_IDLE: if (cmd_valid && rdy_q) begin
        op_d   = cmd_op;
        dst_d  = cmd_dst;
        src1_d = cmd_src1;
        src2_d = cmd_src2;
        // LDI needs no read, so the immediate goes straight into the result register
        if (cmd_op == OP_LDI) begin
          result_d = cmd_imm;
          zero_d   = (cmd_imm == '0);
          carry_d  = 1'b0;
          state_d  = S_WRITE;
        end else begin
          state_d  = S_READ;
        end
      end
      S_READ:  state_d = S_CAPT;
      S_CAPT: begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        carry_d  = alu_c;
        state_d  = (op_q == OP_CMP) ? S_RESP : S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      rdy_q    <= rdy_d;
    end
  end

  // Strobes decode from state only, so an async reset kills them immediately
  assign cmd_ready = rdy_q;
  assign rf_rd     = (state_q == S_READ);
  assign rf_wr     = (state_q == S_WRITE);
  assign rf_en     = rf_rd | rf_wr;
  assign rf_sel_i1 = (state_q == S_IDLE) ? '0 : dst_q;
  assign rf_sel_o1 = (state_q == S_IDLE) ? '0 : src1_q;
  assign rf_sel_o2 = (state_q == S_IDLE) ? '0 : src2_q;
  assign rf_wdata  = result_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = result_q;
  assign rsp_zero  = zero_q;
  assign rsp_carry = carry_q;

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: directed vector table, stall and mid-command reset
// sequences, then a random command stream checked against an architectural model.
module tb_regfile_seq;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_dst, cmd_src1, cmd_src2;
  logic [31:0] cmd_imm;
  logic        rsp_valid, rsp_ready, rsp_zero, rsp_carry;
  logic [31:0] rsp_data;
  logic        rf_en, rf_rd, rf_wr;
  logic [3:0]  rf_sel_i1, rf_sel_o1, rf_sel_o2;
  logic [31:0] rf_wdata, rf_op1, rf_op2;

  regfile_seq #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .rf_en(rf_en), .rf_rd(rf_rd), .rf_wr(rf_wr),
    .rf_sel_i1(rf_sel_i1), .rf_sel_o1(rf_sel_o1), .rf_sel_o2(rf_sel_o2),
    .rf_wdata(rf_wdata), .rf_op1(rf_op1), .rf_op2(rf_op2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file the sequencer talks to: registered reads, write on strobe
  logic [31:0] mem [16] = '{default: 32'd0};
  always @(posedge clk) begin
    if (rf_en && rf_rd) begin
      rf_op1 <= mem[rf_sel_o1];
      rf_op2 <= mem[rf_sel_o2];
    end
    if (rf_en && rf_wr) mem[rf_sel_i1] <= rf_wdata;
  end

  int wr_total = 0;
  int overlap  = 0;
  always @(negedge clk) begin
    if (rf_wr) wr_total <= wr_total + 1;
    if (rf_rd && rf_wr) overlap <= overlap + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural model: registers as a plain array, results from the opcode rules
  logic [31:0] mdl_rf [16] = '{default: 32'd0};

  task automatic model_exec(input logic [2:0] op, input logic [3:0] dst, s1, s2,
                            input logic [31:0] imm,
                            output logic [31:0] d, output logic z, c, output int lat);
    logic [31:0] a, b;
    longint unsigned s;
    a = mdl_rf[s1];
    b = mdl_rf[s2];
    c = 1'b0;
    lat = 4;
    case (op)
      3'd0: begin d = a + b; s = 64'(a) + 64'(b); c = (s > 64'h0000_0000_FFFF_FFFF); end
      3'd1: begin d = a - b; c = (a < b); end
      3'd2: d = a & b;
      3'd3: d = a | b;
      3'd4: d = a ^ b;
      3'd5: d = a;
      3'd6: begin d = imm; lat = 2; end
      default: begin d = a - b; c = (a < b); lat = 3; end
    endcase
    z = (d == 32'd0);
    if (op != 3'd7) mdl_rf[dst] = d;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [3:0] dst, s1, s2,
                         input logic [31:0] imm, input int stall,
                         output logic [31:0] d, output logic z, c,
                         output int lat, wrs, rd_cyc, wr_cyc,
                         output logic [3:0] wsel, output logic [31:0] wdat);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst;
    cmd_src1 = s1; cmd_src2 = s2; cmd_imm = imm;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0; wrs = 0; rd_cyc = -1; wr_cyc = -1; wsel = '0; wdat = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rf_rd && rd_cyc < 0) rd_cyc = k;
      if (rf_wr) begin wrs++; wr_cyc = k; wsel = rf_sel_i1; wdat = rf_wdata; end
      if (rsp_valid) begin lat = k; break; end
    end
    if (lat == 0) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    d = rsp_data; z = rsp_zero; c = rsp_carry;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", rsp_data, d);
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_rsp_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  dst, s1, s2;
    logic [31:0] imm, d;
    logic        z, c;
    int          lat, wrs;
  } vec_t;

  vec_t        tbl [16];
  logic [31:0] d, md;
  logic        z, c, mz, mc;
  int          lat, mlat, wrs, rd_cyc, wr_cyc, w0;
  logic [3:0]  wsel;
  logic [31:0] wdat;

  initial begin
    tbl[0]  = '{3'd6, 4'd3,  4'd0, 4'd0, 32'd5,        32'd5,        1'b0, 1'b0, 2, 1};
    tbl[1]  = '{3'd6, 4'd4,  4'd0, 4'd0, 32'd7,        32'd7,        1'b0, 1'b0, 2, 1};
    tbl[2]  = '{3'd0, 4'd5,  4'd3, 4'd4, 32'd0,        32'd12,       1'b0, 1'b0, 4, 1};
    tbl[3]  = '{3'd6, 4'd1,  4'd0, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 2, 1};
    tbl[4]  = '{3'd6, 4'd2,  4'd0, 4'd0, 32'd1,        32'd1,        1'b0, 1'b0, 2, 1};
    tbl[5]  = '{3'd0, 4'd1,  4'd1, 4'd2, 32'd0,        32'd0,        1'b1, 1'b1, 4, 1};
    tbl[6]  = '{3'd1, 4'd6,  4'd2, 4'd4, 32'd0,        32'hFFFFFFFA, 1'b0, 1'b1, 4, 1};
    tbl[7]  = '{3'd7, 4'd0,  4'd4, 4'd4, 32'd0,        32'd0,        1'b1, 1'b0, 3, 0};
    tbl[8]  = '{3'd2, 4'd7,  4'd3, 4'd4, 32'd0,        32'd5,        1'b0, 1'b0, 4, 1};
    tbl[9]  = '{3'd3, 4'd8,  4'd3, 4'd4, 32'd0,        32'd7,        1'b0, 1'b0, 4, 1};
    tbl[10] = '{3'd4, 4'd9,  4'd3, 4'd4, 32'd0,        32'd2,        1'b0, 1'b0, 4, 1};
    tbl[11] = '{3'd5, 4'd10, 4'd5, 4'd0, 32'd0,        32'd12,       1'b0, 1'b0, 4, 1};
    tbl[12] = '{3'd1, 4'd11, 4'd4, 4'd3, 32'd0,        32'd2,        1'b0, 1'b0, 4, 1};
    tbl[13] = '{3'd0, 4'd3,  4'd3, 4'd3, 32'd0,        32'd10,       1'b0, 1'b0, 4, 1};
    tbl[14] = '{3'd5, 4'd12, 4'd1, 4'd0, 32'd0,        32'd0,        1'b1, 1'b0, 4, 1};
    tbl[15] = '{3'd6, 4'd13, 4'd0, 4'd0, 32'd0,        32'd0,        1'b1, 1'b0, 2, 1};

    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src1 = '0;
    cmd_src2 = '0; cmd_imm = '0; rsp_ready = 1'b0;

    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rf_ctl", {29'd0, rf_en, rf_rd, rf_wr}, 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    foreach (tbl[i]) begin
      run_cmd(tbl[i].op, tbl[i].dst, tbl[i].s1, tbl[i].s2, tbl[i].imm, 0,
              d, z, c, lat, wrs, rd_cyc, wr_cyc, wsel, wdat);
      model_exec(tbl[i].op, tbl[i].dst, tbl[i].s1, tbl[i].s2, tbl[i].imm, md, mz, mc, mlat);
      chk($sformatf("vec%0d_data", i), d, tbl[i].d);
      chk($sformatf("vec%0d_zero", i), 32'(z), 32'(tbl[i].z));
      chk($sformatf("vec%0d_carry", i), 32'(c), 32'(tbl[i].c));
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_wr_pulses", i), wrs, tbl[i].wrs);
      if (tbl[i].wrs > 0) begin
        chk($sformatf("vec%0d_wr_cycle", i), wr_cyc, tbl[i].lat - 1);
        chk($sformatf("vec%0d_wr_sel", i), 32'(wsel), 32'(tbl[i].dst));
        chk($sformatf("vec%0d_wr_data", i), wdat, tbl[i].d);
      end
      if (tbl[i].op != 3'd6) chk($sformatf("vec%0d_rd_cycle", i), rd_cyc, 1);
    end
    chk("r1_written_zero", mem[1], 32'd0);

    // Five-cycle response stall
    run_cmd(3'd0, 4'd15, 4'd3, 4'd4, 32'd0, 5, d, z, c, lat, wrs, rd_cyc, wr_cyc, wsel, wdat);
    model_exec(3'd0, 4'd15, 4'd3, 4'd4, 32'd0, md, mz, mc, mlat);
    chk("stall_rsp_data", d, md);

    // Reset during READ of an ADD: command is dropped, destination untouched
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_dst = 4'd5; cmd_src1 = 4'd3; cmd_src2 = 4'd4;
    chk("mid_rst_accept_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_read", 32'(rf_rd), 32'd1);
    w0 = wr_total;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_rf_ctl", {29'd0, rf_en, rf_rd, rf_wr}, 32'd0);
    chk("mid_rst_sels", {20'd0, rf_sel_i1, rf_sel_o1, rf_sel_o2}, 32'd0);
    chk("mid_rst_rsp", {rsp_data[30:0], rsp_valid} | 32'(rsp_zero) | 32'(rsp_carry), 32'd0);
    chk("mid_rst_wdata", rf_wdata, 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 chk("mid_rst_rel_ready", 32'(cmd_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("mid_rst_no_wr", wr_total, w0);
    run_cmd(3'd5, 4'd14, 4'd5, 4'd0, 32'd0, 0, d, z, c, lat, wrs, rd_cyc, wr_cyc, wsel, wdat);
    model_exec(3'd5, 4'd14, 4'd5, 4'd0, 32'd0, md, mz, mc, mlat);
    chk("mid_rst_readback", d, md);

    for (int i = 0; i < 200; i++) begin
      logic [2:0]  rop;
      logic [3:0]  rd, r1, r2;
      logic [31:0] rimm;
      rop  = 3'($urandom_range(0, 7));
      rd   = 4'($urandom_range(0, 15));
      r1   = 4'($urandom_range(0, 15));
      r2   = 4'($urandom_range(0, 15));
      rimm = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 2)) : $urandom;
      run_cmd(rop, rd, r1, r2, rimm, int'($urandom_range(0, 3)),
              d, z, c, lat, wrs, rd_cyc, wr_cyc, wsel, wdat);
      model_exec(rop, rd, r1, r2, rimm, md, mz, mc, mlat);
      chk($sformatf("rnd%0d_data", i), d, md);
      chk($sformatf("rnd%0d_flags", i), {30'd0, z, c}, {30'd0, mz, mc});
      chk($sformatf("rnd%0d_latency", i), lat, mlat);
      chk($sformatf("rnd%0d_wr_pulses", i), wrs, (rop == 3'd7) ? 0 : 1);
    end

    chk("rd_wr_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
